// File: rtl/weight_mem_arbiter.sv
`timescale 1ns/1ps
// weight_mem_arbiter
//   Owns the single-port synchronous weight memory (1-cycle read latency) and
//   serializes three requesters onto it: the host weight loader (write phase),
//   the inference read port and the learning write-back port. Each access
//   walks IDLE -> ACCESS -> WAIT -> DONE, so one access per 4 cycles.
//   Also issues a 1-cycle datapath start pulse on entry to inference.
//
//   Build option: define WMA_RR_EN for round-robin rd/wb arbitration;
//   otherwise write-back has fixed priority over reads.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   phase_infer                     0 = host write phase, 1 = inference/learning
//   host_req/host_addr/host_wdata   host write request (level), host_ack pulse
//   rd_req/rd_addr                  datapath read request (level)
//   rd_valid/rd_data                read done pulse, data held until next read
//   wb_req/wb_addr/wb_wdata         write-back request (level), wb_ack pulse
//   mem_we/mem_addr/mem_wdata       registered memory command
//   mem_rdata                       memory read data
//   ml_start                        datapath start pulse
//   busy                            high whenever the FSM is not IDLE
module weight_mem_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_infer,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DW-1:0]     host_wdata,
  output logic              host_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DW-1:0]     wb_wdata,
  output logic              wb_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              ml_start,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_HOST, G_RD, G_WB} grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              wb_ack_q, wb_ack_d;
  logic              phase_q;
  logic              start_pend_q, start_pend_d;
`ifdef WMA_RR_EN
  logic              rr_wb_q, rr_wb_d;   // 1: write-back was the last phase-1 grant
`endif

  logic host_el, rd_el, wb_el, pick_wb;

  // Eligibility uses the registered phase so that a rising phase edge first
  // shows ml_start in IDLE before any phase-1 request can be granted.
  always_comb begin
    host_el = ~phase_q & host_req;
    rd_el   =  phase_q & rd_req;
    wb_el   =  phase_q & wb_req;
`ifdef WMA_RR_EN
    pick_wb = wb_el & (~rd_el | ~rr_wb_q);
`else
    pick_wb = wb_el;
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    host_ack_d   = 1'b0;
    rd_valid_d   = 1'b0;
    wb_ack_d     = 1'b0;
    rd_data_d    = rd_data_q;
`ifdef WMA_RR_EN
    rr_wb_d      = rr_wb_q;
`endif
    // A pending start survives a busy period and is consumed in IDLE; a new
    // rising edge always re-arms it.
    start_pend_d = (phase_infer & ~phase_q) | (start_pend_q & (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (host_el) begin
          grant_d     = G_HOST;
          mem_we_d    = 1'b1;
          mem_addr_d  = host_addr;
          mem_wdata_d = host_wdata;
          state_d     = S_ACCESS;
        end else if (pick_wb) begin
          grant_d     = G_WB;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr;
          mem_wdata_d = wb_wdata;
          state_d     = S_ACCESS;
`ifdef WMA_RR_EN
          rr_wb_d     = 1'b1;
`endif
        end else if (rd_el) begin
          grant_d     = G_RD;
          mem_addr_d  = rd_addr;
          state_d     = S_ACCESS;
`ifdef WMA_RR_EN
          rr_wb_d     = 1'b0;
`endif
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        unique case (grant_q)
          G_HOST:  host_ack_d = 1'b1;
          G_WB:    wb_ack_d   = 1'b1;
          G_RD: begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_rdata;
          end
          default: ;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= G_NONE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      host_ack_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      wb_ack_q     <= 1'b0;
      phase_q      <= 1'b0;
      start_pend_q <= 1'b0;
`ifdef WMA_RR_EN
      rr_wb_q      <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      host_ack_q   <= host_ack_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      wb_ack_q     <= wb_ack_d;
      phase_q      <= phase_infer;
      start_pend_q <= start_pend_d;
`ifdef WMA_RR_EN
      rr_wb_q      <= rr_wb_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign host_ack  = host_ack_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wb_ack    = wb_ack_q;
  assign ml_start  = start_pend_q & (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_weight_mem_arbiter.sv
`timescale 1ns/1ps
module tb_weight_mem_arbiter;

  localparam int ADDR_W = 4;
  localparam int DW     = 8;
  localparam int K_HOST = 0;
  localparam int K_RD   = 1;
  localparam int K_WB   = 2;

  logic              clk, rst_n, phase_infer;
  logic              host_req, host_ack;
  logic [ADDR_W-1:0] host_addr;
  logic [DW-1:0]     host_wdata;
  logic              rd_req, rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic              wb_req, wb_ack;
  logic [ADDR_W-1:0] wb_addr;
  logic [DW-1:0]     wb_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              ml_start, busy;

  weight_mem_arbiter #(.ADDR_W(ADDR_W), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .phase_infer(phase_infer),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_ack(wb_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ml_start(ml_start), .busy(busy)
  );

  // Single-port synchronous memory, 1-cycle read latency
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int kind; logic [7:0] data; } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int we_cnt, ml_cnt, rv_cnt, busy_cnt;
  bit last_wb = 1'b1;
  bit rd_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mem_we)   we_cnt++;
    if (ml_start) ml_cnt++;
    if (rd_valid) rv_cnt++;
    if (busy)     busy_cnt++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_host_ack"},  32'(host_ack),  32'd0);
    check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, "_rd_data"},   32'(rd_data),   32'd0);
    check({tag, "_wb_ack"},    32'(wb_ack),    32'd0);
    check({tag, "_ml_start"},  32'(ml_start),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Runs the clock until every queued expectation has been matched by a
  // response pulse; optionally raises phase_infer during the ACCESS cycle.
  task automatic serve(input int budget, input bit flip);
    int k;
    bit started;
    exp_t e;
    int obs;
    k = 0; started = 0; we_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < budget && q.size() > 0; i++) begin
      step();
      if (!started && busy) started = 1;
      if (started) k++;
      if (flip && k == 1) phase_infer = 1'b1;
      if (host_ack || rd_valid || wb_ack) begin
        e   = q.pop_front();
        obs = host_ack ? K_HOST : (rd_valid ? K_RD : K_WB);
        check("resp_kind", 32'(obs), 32'(e.kind));
        check("latency", 32'(k), 32'd3);
        check("busy_cycles", 32'(busy_cnt), 32'd3);
        check("we_pulse", 32'(we_cnt), (e.kind == K_RD) ? 32'd0 : 32'd1);
        check("single_pulse", 32'(host_ack) + 32'(rd_valid) + 32'(wb_ack), 32'd1);
        if (e.kind == K_RD) check("rd_data", 32'(rd_data), 32'(e.data));
        if (obs == K_HOST) host_req = 1'b0;
        if (obs == K_RD)   rd_req   = 1'b0;
        if (obs == K_WB)   wb_req   = 1'b0;
        started = 0; k = 0; we_cnt = 0; busy_cnt = 0;
      end
    end
    check("timeout_pending", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0; phase_infer = 1'b0;
    host_req = 1'b0; host_addr = '0; host_wdata = '0;
    rd_req = 1'b0; rd_addr = '0;
    wb_req = 1'b0; wb_addr = '0; wb_wdata = '0;
    we_cnt = 0; ml_cnt = 0; rv_cnt = 0; busy_cnt = 0;

    // Reset state
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Host load: two writes in write phase
    host_req = 1'b1; host_addr = 4'd3; host_wdata = 8'h5A;
    q.push_back('{K_HOST, 8'h00});
    serve(20, 1'b0);
    host_req = 1'b1; host_addr = 4'd15; host_wdata = 8'hC3;
    q.push_back('{K_HOST, 8'h00});
    serve(20, 1'b0);
    step();
    check("mem3", 32'(mem[3]), 32'h5A);
    check("mem15", 32'(mem[15]), 32'hC3);

    // Phase rise with no traffic: one ml_start pulse, then read latency
    step();
    ml_cnt = 0;
    phase_infer = 1'b1;
    step();
    check("ml_start_rise", 32'(ml_start), 32'd1);
    step();
    check("ml_start_once", 32'(ml_cnt), 32'd1);
    rd_req = 1'b1; rd_addr = 4'd3;
    q.push_back('{K_RD, 8'h5A});
    serve(20, 1'b0);
    last_wb = 1'b0;

    // Collision: wb and rd to the same address in the same cycle
    step();
`ifdef WMA_RR_EN
    rd_first = !last_wb ? 1'b0 : 1'b1;
`else
    rd_first = 1'b0;
`endif
    wb_req = 1'b1; wb_addr = 4'd3; wb_wdata = 8'h11;
    rd_req = 1'b1; rd_addr = 4'd3;
    if (rd_first) begin
      q.push_back('{K_RD, 8'h5A});
      q.push_back('{K_WB, 8'h00});
    end else begin
      q.push_back('{K_WB, 8'h00});
      q.push_back('{K_RD, 8'h11});
    end
    serve(40, 1'b0);
    check("mem3_wb", 32'(mem[3]), 32'h11);

    // Phase gating: read held in write phase is not served
    step();
    phase_infer = 1'b0;
    step(); step();
    rd_req = 1'b1; rd_addr = 4'd15;
    busy_cnt = 0; rv_cnt = 0;
    repeat (6) step();
    check("gate_busy", 32'(busy_cnt), 32'd0);
    check("gate_rd_valid", 32'(rv_cnt), 32'd0);
    ml_cnt = 0;
    phase_infer = 1'b1;
    step();
    check("gate_ml_start", 32'(ml_start), 32'd1);
    check("gate_idle", 32'(busy), 32'd0);
    q.push_back('{K_RD, 8'hC3});
    serve(20, 1'b0);
    check("gate_ml_once", 32'(ml_cnt), 32'd1);

    // Phase switch during a host write's ACCESS cycle
    step();
    phase_infer = 1'b0;
    step(); step();
    ml_cnt = 0;
    host_req = 1'b1; host_addr = 4'd7; host_wdata = 8'h3C;
    q.push_back('{K_HOST, 8'h00});
    serve(20, 1'b1);
    check("switch_no_early_start", 32'(ml_cnt), 32'd0);
    step();
    check("switch_ml_start_idle", 32'(ml_start), 32'd1);
    check("switch_idle", 32'(busy), 32'd0);
    step();
    check("switch_ml_start_end", 32'(ml_start), 32'd0);

    // Write then read of the same address returns the new data; rd_data held
    rd_req = 1'b1; rd_addr = 4'd7;
    q.push_back('{K_RD, 8'h3C});
    serve(20, 1'b0);
    step(); step(); step();
    check("rd_data_hold", 32'(rd_data), 32'h3C);

    // Reset during WAIT of a read
    rd_req = 1'b1; rd_addr = 4'd3;
    for (int i = 0; i < 8 && !busy; i++) step();
    check("rst_granted", 32'(busy), 32'd1);
    step();
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    rd_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_cnt = 0;
    repeat (6) step();
    check("post_rst_no_valid", 32'(rv_cnt), 32'd0);
    rd_req = 1'b1; rd_addr = 4'd3;
    q.push_back('{K_RD, 8'h11});
    serve(20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
